// File: rtl/alu_sequencer_if.sv
// Bus bundle between alu_sequencer and its program memory / combinational ALU.
// master = sequencer side, slave = memory + ALU side.
interface alu_sequencer_if #(
  parameter int PC_WIDTH = 8
);
  logic [PC_WIDTH-1:0] instr_addr;
  logic                instr_req;
  logic [15:0]         instr_data;
  logic                instr_valid;
  logic [3:0]          alu_opcode;
  logic [7:0]          alu_a;
  logic [7:0]          alu_b;
  logic [7:0]          alu_load_number;
  logic [7:0]          alu_out;
  logic [3:0]          alu_flag;

  modport master (
    output instr_addr, instr_req, alu_opcode, alu_a, alu_b, alu_load_number,
    input  instr_data, instr_valid, alu_out, alu_flag
  );

  modport slave (
    input  instr_addr, instr_req, alu_opcode, alu_a, alu_b, alu_load_number,
    output instr_data, instr_valid, alu_out, alu_flag
  );
endinterface

// File: rtl/alu_sequencer.sv
// Fetch/decode/execute/writeback sequencer driving a combinational ALU from 16-bit program words.
// Optional branch opcodes (JZ/JC/JMP) are enabled by defining SEQ_BRANCH_EN.
module alu_sequencer #(
  parameter int          PC_WIDTH      = 8,
  parameter int          FETCH_TIMEOUT = 16,
  parameter logic [3:0]  IDLE_OPCODE   = 4'b1111
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  alu_sequencer_if.master       bus,
  output logic                  busy,
  output logic                  halted,
  output logic                  fetch_err,
  output logic [3:0]            flags,
  input  logic [1:0]            dbg_sel,
  output logic [7:0]            dbg_data
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXECUTE, S_WRITEBACK, S_HALT
  } state_e;

  typedef struct packed {
    logic [3:0] op;
    logic [1:0] rd;
    logic [1:0] rs;
    logic [7:0] imm;
  } instr_t;

  localparam logic [3:0] OP_LOAD = 4'hE;
  localparam logic [3:0] OP_HALT = 4'hF;
`ifdef SEQ_BRANCH_EN
  localparam logic [3:0] OP_JZ      = 4'h8;
  localparam logic [3:0] OP_JC      = 4'h9;
  localparam logic [3:0] OP_JMP     = 4'hA;
  localparam logic [3:0] FLAG_ZERO  = 4'b0010;
  localparam logic [3:0] FLAG_CARRY = 4'b1000;
`endif

  localparam int                  TMO_W    = $clog2(FETCH_TIMEOUT + 1);
  localparam logic [TMO_W-1:0]    TMO_LAST = TMO_W'(FETCH_TIMEOUT - 1);
  localparam logic [TMO_W-1:0]    TMO_ONE  = TMO_W'(1);
  localparam logic [PC_WIDTH-1:0] PC_ONE   = PC_WIDTH'(1);

  state_e              state_q, state_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic [3:0]          op_q, op_d;
  logic [1:0]          rd_q, rd_d;
  logic [7:0]          imm_q, imm_d;
  logic [7:0]          a_q, a_d;
  logic [7:0]          b_q, b_d;
  logic [3:0][7:0]     regs_q, regs_d;
  logic [3:0]          flags_q, flags_d;
  logic [7:0]          res_q, res_d;
  logic [3:0]          res_flag_q, res_flag_d;
  logic [TMO_W-1:0]    tmo_q, tmo_d;
  logic                fetch_err_q, fetch_err_d;

  instr_t              fetched;
  logic [PC_WIDTH-1:0] pc_inc;

  assign fetched = instr_t'(bus.instr_data);
  assign pc_inc  = pc_q + PC_ONE;

`ifdef SEQ_BRANCH_EN
  logic [PC_WIDTH-1:0] target;
  assign target = PC_WIDTH'(imm_q);
`endif

  always_comb begin
    // NOTE: every *_d gets a default before the case so no path leaves it unassigned (no latches).
    state_d     = state_q;
    pc_d        = pc_q;
    op_d        = op_q;
    rd_d        = rd_q;
    imm_d       = imm_q;
    a_d         = a_q;
    b_d         = b_q;
    regs_d      = regs_q;
    flags_d     = flags_q;
    res_d       = res_q;
    res_flag_d  = res_flag_q;
    tmo_d       = '0;
    fetch_err_d = fetch_err_q;

    unique case (state_q)
      S_IDLE: if (start) state_d = S_FETCH;

      S_FETCH: begin
        if (bus.instr_valid) begin
          // Operands are snapshotted here so they are already stable during DECODE.
          op_d    = fetched.op;
          rd_d    = fetched.rd;
          imm_d   = fetched.imm;
          a_d     = regs_q[fetched.rd];
          b_d     = regs_q[fetched.rs];
          state_d = S_DECODE;
        end else if (tmo_q == TMO_LAST) begin
          fetch_err_d = 1'b1;
          state_d     = S_HALT;
        end else begin
          tmo_d = tmo_q + TMO_ONE;
        end
      end

      S_DECODE: begin
        state_d = S_FETCH;
        pc_d    = pc_inc;
        case (op_q)
          OP_HALT: begin
            state_d = S_HALT;
            pc_d    = pc_q;
          end
          4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, OP_LOAD: begin
            state_d = S_EXECUTE;
            pc_d    = pc_q;
          end
`ifdef SEQ_BRANCH_EN
          OP_JZ:  if (flags_q == FLAG_ZERO)  pc_d = target;
          OP_JC:  if (flags_q == FLAG_CARRY) pc_d = target;
          OP_JMP: pc_d = target;
`endif
          default: ;
        endcase
      end

      S_EXECUTE: begin
        res_d      = bus.alu_out;
        res_flag_d = bus.alu_flag;
        state_d    = S_WRITEBACK;
      end

      S_WRITEBACK: begin
        regs_d[rd_q] = res_q;
        if (op_q != OP_LOAD) flags_d = res_flag_q;
        pc_d    = pc_inc;
        state_d = S_FETCH;
      end

      S_HALT: begin
        if (start) begin
          pc_d    = '0;
          state_d = S_FETCH;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: the 4-entry register file is reset like any other flop so R0-R3 read 0 after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      pc_q        <= '0;
      op_q        <= '0;
      rd_q        <= '0;
      imm_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      regs_q      <= '0;
      flags_q     <= '0;
      res_q       <= '0;
      res_flag_q  <= '0;
      tmo_q       <= '0;
      fetch_err_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge value of the others.
      state_q     <= state_d;
      pc_q        <= pc_d;
      op_q        <= op_d;
      rd_q        <= rd_d;
      imm_q       <= imm_d;
      a_q         <= a_d;
      b_q         <= b_d;
      regs_q      <= regs_d;
      flags_q     <= flags_d;
      res_q       <= res_d;
      res_flag_q  <= res_flag_d;
      tmo_q       <= tmo_d;
      fetch_err_q <= fetch_err_d;
    end
  end

  // The ALU only re-evaluates on an opcode change, so the opcode is idle outside EXECUTE.
  assign bus.alu_opcode      = (state_q == S_EXECUTE) ? op_q : IDLE_OPCODE;
  assign bus.alu_a           = a_q;
  assign bus.alu_b           = b_q;
  assign bus.alu_load_number = imm_q;
  assign bus.instr_addr      = pc_q;
  assign bus.instr_req       = (state_q == S_FETCH);

  assign busy      = (state_q != S_IDLE) && (state_q != S_HALT);
  assign halted    = (state_q == S_HALT);
  assign fetch_err = fetch_err_q;
  assign flags     = flags_q;
  assign dbg_data  = regs_q[dbg_sel];

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer: combinational program memory plus an ALU model
// that only evaluates when its opcode changes.
module tb_alu_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [1:0] dbg_sel = 2'd0;
  logic       busy, halted, fetch_err;
  logic [3:0] flags;
  logic [7:0] dbg_data;

  int n_tests = 0;
  int n_fail  = 0;

`ifdef SEQ_BRANCH_EN
  localparam bit BR_EN = 1'b1;
`else
  localparam bit BR_EN = 1'b0;
`endif

  localparam logic [15:0] HALT_W = 16'hF000;
  localparam logic [15:0] NOP_W  = 16'hB000;

  alu_sequencer_if #(.PC_WIDTH(8)) bus ();

  alu_sequencer #(
    .PC_WIDTH(8), .FETCH_TIMEOUT(16), .IDLE_OPCODE(4'b1111)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .bus(bus),
    .busy(busy), .halted(halted), .fetch_err(fetch_err), .flags(flags),
    .dbg_sel(dbg_sel), .dbg_data(dbg_data)
  );

  always #5 clk = ~clk;

  // Program memory: answers in the same cycle a request is seen, below valid_limit.
  logic [15:0] mem [256];
  int          valid_limit  = 256;
  bit          always_valid = 1'b0;

  assign bus.instr_valid = always_valid ? 1'b1
                         : (bus.instr_req && (int'(bus.instr_addr) < valid_limit));
  assign bus.instr_data  = (always_valid && !bus.instr_req) ? HALT_W : mem[bus.instr_addr];

  // ALU model: evaluates only on an opcode change, holds its outputs otherwise.
  logic [7:0] alu_out_r  = 8'h00;
  logic [3:0] alu_flag_r = 4'b0000;
  assign bus.alu_out  = alu_out_r;
  assign bus.alu_flag = alu_flag_r;

  always @(bus.alu_opcode) begin : alu_model
    logic [8:0] sum;
    logic [7:0] a, b;
    a   = bus.alu_a;
    b   = bus.alu_b;
    sum = {1'b0, a} + {1'b0, b};
    if (bus.alu_opcode != 4'hF) begin
      alu_flag_r = 4'b0000;
      case (bus.alu_opcode)
        4'h0: begin
          alu_out_r = sum[7:0];
          if (sum[8]) alu_flag_r = 4'b1000;
          else if (sum[7:0] == 8'h00) alu_flag_r = 4'b0010;
        end
        4'h1: begin
          alu_out_r = a - b;
          if (a < b) alu_flag_r = 4'b0100;
          else if (a == b) alu_flag_r = 4'b0010;
        end
        4'h2, 4'h3, 4'h4, 4'h5, 4'h6: begin
          case (bus.alu_opcode)
            4'h2:    alu_out_r = a & b;
            4'h3:    alu_out_r = a | b;
            4'h4:    alu_out_r = a ^ b;
            4'h5:    alu_out_r = a << 1;
            default: alu_out_r = a >> 1;
          endcase
          if (alu_out_r == 8'h00) alu_flag_r = 4'b0010;
        end
        4'hE:    alu_out_r = bus.alu_load_number;
        default: alu_out_r = 8'h00;
      endcase
    end
  end

  function automatic logic [15:0] enc(input logic [3:0] op, input logic [1:0] rd,
                                      input logic [1:0] rs, input logic [7:0] imm);
    return {op, rd, rs, imm};
  endfunction

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) mem[i] = HALT_W;
  endtask

  task automatic read_reg(input logic [1:0] idx, output logic [7:0] v);
    dbg_sel = idx;
    #1;
    v = dbg_data;
  endtask

  // Run bookkeeping observed at negedges while a program runs.
  int       xor_cycles, xor_entries;
  bit       saw_f0;
  logic [3:0] prev_op;

  // Pulses start, counts edges until halted (edge 0 = the edge that samples start).
  task automatic run_prog(input int budget, input int restart_at, output int cycles);
    xor_cycles = 0; xor_entries = 0; saw_f0 = 1'b0; prev_op = 4'hF;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    cycles = 0;
    while (halted !== 1'b1 && cycles < budget) begin
      @(negedge clk);
      start = (cycles == restart_at);
      if (bus.alu_opcode == 4'h4) begin
        xor_cycles++;
        if (prev_op == 4'hF) xor_entries++;
      end
      prev_op = bus.alu_opcode;
      if (dbg_data == 8'hF0) saw_f0 = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      cycles++;
    end
    n_tests++;
    if (halted !== 1'b1) begin
      n_fail++;
      $display("FAIL run_halt_timeout: halted=%b after %0d cycles, expected 1", halted, cycles);
    end
  endtask

  task automatic test_reset();
    logic [7:0] v;
    #12;
    n_tests++; if (bus.alu_opcode !== 4'hF) begin n_fail++; $display("FAIL rst_opcode: got %h exp f", bus.alu_opcode); end
    n_tests++; if (bus.instr_req !== 1'b0) begin n_fail++; $display("FAIL rst_req: got %b exp 0", bus.instr_req); end
    n_tests++; if (bus.instr_addr !== 8'h00) begin n_fail++; $display("FAIL rst_addr: got %h exp 00", bus.instr_addr); end
    n_tests++; if ({bus.alu_a, bus.alu_b, bus.alu_load_number} !== 24'h0) begin n_fail++; $display("FAIL rst_operands: got %h exp 000000", {bus.alu_a, bus.alu_b, bus.alu_load_number}); end
    n_tests++; if ({busy, halted, fetch_err, flags} !== 7'b0) begin n_fail++; $display("FAIL rst_status: got %b exp 0000000", {busy, halted, fetch_err, flags}); end
    for (int i = 0; i < 4; i++) begin
      read_reg(i[1:0], v);
      n_tests++; if (v !== 8'h00) begin n_fail++; $display("FAIL rst_reg%0d: got %h exp 00", i, v); end
    end
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    n_tests++; if ({busy, halted} !== 2'b00) begin n_fail++; $display("FAIL idle_no_start: busy/halted=%b exp 00", {busy, halted}); end
  endtask

  task automatic test_program();
    int cyc;
    logic [7:0] v;
    clear_mem();
    mem[0] = enc(4'hE, 2'd0, 2'd0, 8'h05);
    mem[1] = enc(4'hE, 2'd1, 2'd0, 8'h03);
    mem[2] = enc(4'h0, 2'd0, 2'd1, 8'h00);
    run_prog(60, 5, cyc);  // second start pulse while busy must be ignored
    n_tests++; if (cyc !== 14) begin n_fail++; $display("FAIL prog_latency: got %0d cycles exp 14", cyc); end
    read_reg(2'd0, v);
    n_tests++; if (v !== 8'h08) begin n_fail++; $display("FAIL prog_r0: got %h exp 08", v); end
    read_reg(2'd1, v);
    n_tests++; if (v !== 8'h03) begin n_fail++; $display("FAIL prog_r1: got %h exp 03", v); end
    n_tests++; if (flags !== 4'b0000) begin n_fail++; $display("FAIL prog_flags: got %b exp 0000", flags); end
    n_tests++; if ({busy, halted} !== 2'b01) begin n_fail++; $display("FAIL prog_halt_state: busy/halted=%b exp 01", {busy, halted}); end
    n_tests++; if (bus.instr_addr !== 8'h03) begin n_fail++; $display("FAIL prog_halt_pc: got %h exp 03", bus.instr_addr); end
  endtask

  task automatic test_flags();
    int cyc;
    logic [7:0] v;
    clear_mem();
    mem[0] = enc(4'hE, 2'd0, 2'd0, 8'hF0);
    mem[1] = enc(4'hE, 2'd1, 2'd0, 8'h20);
    mem[2] = enc(4'h0, 2'd0, 2'd1, 8'h00);
    run_prog(60, -1, cyc);
    read_reg(2'd0, v);
    n_tests++; if (v !== 8'h10) begin n_fail++; $display("FAIL carry_r0: got %h exp 10", v); end
    n_tests++; if (flags !== 4'b1000) begin n_fail++; $display("FAIL carry_flags: got %b exp 1000", flags); end

    clear_mem();
    mem[0] = enc(4'hE, 2'd3, 2'd0, 8'h55);
    run_prog(30, -1, cyc);
    read_reg(2'd3, v);
    n_tests++; if (v !== 8'h55) begin n_fail++; $display("FAIL load_r3: got %h exp 55", v); end
    n_tests++; if (flags !== 4'b1000) begin n_fail++; $display("FAIL load_keeps_flags: got %b exp 1000", flags); end

    clear_mem();
    mem[0] = enc(4'hE, 2'd2, 2'd0, 8'h07);
    mem[1] = enc(4'hE, 2'd3, 2'd0, 8'h07);
    mem[2] = enc(4'h1, 2'd2, 2'd3, 8'h00);
    run_prog(60, -1, cyc);
    read_reg(2'd2, v);
    n_tests++; if (v !== 8'h00) begin n_fail++; $display("FAIL zero_r2: got %h exp 00", v); end
    n_tests++; if (flags !== 4'b0010) begin n_fail++; $display("FAIL zero_flags: got %b exp 0010", flags); end

    clear_mem();
    mem[0] = enc(4'hE, 2'd0, 2'd0, 8'h03);
    mem[1] = enc(4'hE, 2'd1, 2'd0, 8'h05);
    mem[2] = enc(4'h1, 2'd0, 2'd1, 8'h00);
    run_prog(60, -1, cyc);
    read_reg(2'd0, v);
    n_tests++; if (v !== 8'hFE) begin n_fail++; $display("FAIL neg_r0: got %h exp fe", v); end
    n_tests++; if (flags !== 4'b0100) begin n_fail++; $display("FAIL neg_flags: got %b exp 0100", flags); end
  endtask

  task automatic test_back_to_back();
    int cyc;
    logic [7:0] v;
    clear_mem();
    mem[0] = enc(4'hE, 2'd2, 2'd0, 8'h0F);
    mem[1] = enc(4'hE, 2'd3, 2'd0, 8'hFF);
    mem[2] = enc(4'h4, 2'd2, 2'd3, 8'h00);
    mem[3] = enc(4'h4, 2'd2, 2'd3, 8'h00);
    dbg_sel = 2'd2;
    run_prog(60, -1, cyc);
    n_tests++; if (cyc !== 18) begin n_fail++; $display("FAIL b2b_latency: got %0d exp 18", cyc); end
    n_tests++; if (xor_entries !== 2) begin n_fail++; $display("FAIL b2b_idle_between: xor entries from 1111 got %0d exp 2", xor_entries); end
    n_tests++; if (xor_cycles !== 2) begin n_fail++; $display("FAIL b2b_exec_cycles: got %0d exp 2", xor_cycles); end
    n_tests++; if (saw_f0 !== 1'b1) begin n_fail++; $display("FAIL b2b_first_result: R2=f0 seen=%b exp 1", saw_f0); end
    read_reg(2'd2, v);
    n_tests++; if (v !== 8'h0F) begin n_fail++; $display("FAIL b2b_final_r2: got %h exp 0f", v); end
    n_tests++; if (flags !== 4'b0000) begin n_fail++; $display("FAIL b2b_flags: got %b exp 0000", flags); end
  endtask

  task automatic test_nop_latency();
    int cyc;
    clear_mem();
    mem[0] = NOP_W;
    run_prog(30, -1, cyc);
    n_tests++; if (cyc !== 4) begin n_fail++; $display("FAIL nop_latency: got %0d exp 4", cyc); end
    n_tests++; if (bus.instr_addr !== 8'h01) begin n_fail++; $display("FAIL nop_pc: got %h exp 01", bus.instr_addr); end
    n_tests++; if (flags !== 4'b0000) begin n_fail++; $display("FAIL nop_flags: got %b exp 0000", flags); end
  endtask

  task automatic test_branch();
    int cyc;
    clear_mem();
    mem[0] = enc(4'hE, 2'd0, 2'd0, 8'h07);
    mem[1] = enc(4'hE, 2'd1, 2'd0, 8'h07);
    mem[2] = enc(4'h1, 2'd0, 2'd1, 8'h00);
    mem[3] = NOP_W;
    mem[4] = enc(4'h8, 2'd0, 2'd0, 8'h20);
    run_prog(80, -1, cyc);
    n_tests++; if (bus.instr_addr !== (BR_EN ? 8'h20 : 8'h05)) begin n_fail++; $display("FAIL jz_taken_addr: got %h exp %h", bus.instr_addr, BR_EN ? 8'h20 : 8'h05); end

    mem[0] = enc(4'hE, 2'd0, 2'd0, 8'h05);
    mem[1] = enc(4'hE, 2'd1, 2'd0, 8'h03);
    mem[2] = enc(4'h0, 2'd0, 2'd1, 8'h00);
    run_prog(80, -1, cyc);
    n_tests++; if (bus.instr_addr !== 8'h05) begin n_fail++; $display("FAIL jz_not_taken_addr: got %h exp 05", bus.instr_addr); end

    clear_mem();
    mem[0] = enc(4'hA, 2'd0, 2'd0, 8'h30);
    run_prog(30, -1, cyc);
    n_tests++; if (bus.instr_addr !== (BR_EN ? 8'h30 : 8'h01)) begin n_fail++; $display("FAIL jmp_addr: got %h exp %h", bus.instr_addr, BR_EN ? 8'h30 : 8'h01); end
  endtask

  task automatic test_pc_wrap();
    bit seen, done;
    for (int i = 0; i < 256; i++) mem[i] = NOP_W;
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 700 && !seen; k++) begin
      @(negedge clk);
      if (bus.instr_addr == 8'hFF) seen = 1'b1;
    end
    n_tests++; if (seen !== 1'b1) begin n_fail++; $display("FAIL wrap_reach_ff: seen=%b exp 1", seen); end
    mem[0] = HALT_W;
    done = 1'b0;
    for (int k = 0; k < 20 && !done; k++) begin
      @(negedge clk);
      if (halted === 1'b1) done = 1'b1;
    end
    n_tests++; if (done !== 1'b1) begin n_fail++; $display("FAIL wrap_halt: halted=%b exp 1", halted); end
    n_tests++; if (bus.instr_addr !== 8'h00) begin n_fail++; $display("FAIL wrap_pc: got %h exp 00", bus.instr_addr); end
  endtask

  task automatic test_valid_outside_fetch();
    int cyc;
    logic [7:0] v;
    clear_mem();
    mem[0] = enc(4'hE, 2'd1, 2'd0, 8'h11);
    mem[1] = enc(4'hE, 2'd2, 2'd0, 8'h22);
    mem[2] = enc(4'h3, 2'd1, 2'd2, 8'h00);
    always_valid = 1'b1;
    run_prog(60, -1, cyc);
    always_valid = 1'b0;
    n_tests++; if (cyc !== 14) begin n_fail++; $display("FAIL vof_latency: got %0d exp 14", cyc); end
    read_reg(2'd1, v);
    n_tests++; if (v !== 8'h33) begin n_fail++; $display("FAIL vof_r1: got %h exp 33", v); end
  endtask

  task automatic test_fetch_timeout();
    int cyc;
    logic [7:0] v;
    clear_mem();
    mem[0] = enc(4'hE, 2'd0, 2'd0, 8'h01);
    mem[1] = enc(4'hE, 2'd1, 2'd0, 8'h02);
    valid_limit = 2;
    run_prog(60, -1, cyc);
    n_tests++; if (cyc !== 24) begin n_fail++; $display("FAIL tmo_cycles: got %0d exp 24", cyc); end
    n_tests++; if ({fetch_err, halted, busy} !== 3'b110) begin n_fail++; $display("FAIL tmo_status: err/halted/busy=%b exp 110", {fetch_err, halted, busy}); end
    n_tests++; if (bus.instr_addr !== 8'h02) begin n_fail++; $display("FAIL tmo_pc: got %h exp 02", bus.instr_addr); end
    read_reg(2'd0, v);
    n_tests++; if (v !== 8'h01) begin n_fail++; $display("FAIL tmo_r0: got %h exp 01", v); end
    valid_limit = 256;
    clear_mem();
    run_prog(30, -1, cyc);
    n_tests++; if (fetch_err !== 1'b1) begin n_fail++; $display("FAIL tmo_sticky: got %b exp 1", fetch_err); end
  endtask

  task automatic test_reset_mid_execute();
    bit found;
    logic [7:0] v;
    clear_mem();
    mem[0] = enc(4'hE, 2'd0, 2'd0, 8'h05);
    mem[1] = enc(4'hE, 2'd1, 2'd0, 8'h03);
    mem[2] = enc(4'h0, 2'd0, 2'd1, 8'h00);
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 40 && !found; k++) begin
      @(negedge clk);
      if (bus.alu_opcode == 4'h0) found = 1'b1;
    end
    n_tests++; if (found !== 1'b1) begin n_fail++; $display("FAIL rme_reach_execute: found=%b exp 1", found); end
    rst = 1'b1;
    #1;
    n_tests++; if (bus.alu_opcode !== 4'hF) begin n_fail++; $display("FAIL rme_opcode: got %h exp f", bus.alu_opcode); end
    n_tests++; if ({busy, halted, bus.instr_req} !== 3'b000) begin n_fail++; $display("FAIL rme_status: busy/halted/req=%b exp 000", {busy, halted, bus.instr_req}); end
    n_tests++; if (bus.alu_a !== 8'h00) begin n_fail++; $display("FAIL rme_alu_a: got %h exp 00", bus.alu_a); end
    @(posedge clk);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    read_reg(2'd0, v);
    n_tests++; if (v !== 8'h00) begin n_fail++; $display("FAIL rme_r0: got %h exp 00", v); end
    n_tests++; if ({fetch_err, flags, busy, halted} !== 7'b0) begin n_fail++; $display("FAIL rme_after: err/flags/busy/halted=%b exp 0000000", {fetch_err, flags, busy, halted}); end
  endtask

  initial begin
    clear_mem();
    test_reset();
    test_program();
    test_flags();
    test_back_to_back();
    test_nop_latency();
    test_branch();
    test_pc_wrap();
    test_valid_outside_fetch();
    test_fetch_timeout();
    test_reset_mid_execute();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_sequencer.md
Name: alu_sequencer

Overview:
Control-side counterpart of the arithmetic/logic unit. The block fetches 16-bit instructions from program memory and drives the ALU's opcode, operand and load-number inputs. It captures the ALU result and flags into an internal 4x8 register file and flag register. It sits between program memory and the combinational ALU, and is the initiator of every ALU operation.

Parameters:
PC_WIDTH, 8, program counter / instruction address width
FETCH_TIMEOUT, 16, cycles to wait for instr_valid before declaring a fetch error
IDLE_OPCODE, 4'b1111, value driven on alu_opcode whenever no operation is presented

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-high
start  in  1  one-cycle pulse; begins execution at pc=0
instr_addr  out  PC_WIDTH  program-memory address (= pc)
instr_req  out  1  fetch request, held until instr_valid
instr_data  in  16  instruction word
instr_valid  in  1  instr_data valid this cycle
alu_opcode  out  4  ALU opcode
alu_a  out  8  ALU operand a
alu_b  out  8  ALU operand b
alu_load_number  out  8  immediate for the ALU load op
alu_out  in  8  ALU result
alu_flag  in  4  ALU flags (1000 carry, 0100 negative, 0010 zero, 0000 none)
busy  out  1  high from start accepted until HALT state
halted  out  1  high in HALT state
fetch_err  out  1  sticky; set on fetch timeout
flags  out  4  current flag register
dbg_sel  in  2  register-file index for debug read
dbg_data  out  8  R[dbg_sel], combinational

Behaviour:
- Reset (asynchronous, active-high, takes effect immediately, including mid-instruction):
  - State goes to IDLE; pc=0; R0-R3=0; flags=0000.
  - instr_req=0; alu_opcode=IDLE_OPCODE; alu_a, alu_b and alu_load_number = 0.
  - busy=0; halted=0; fetch_err=0.
  - No register writeback occurs for an interrupted instruction.
- Instruction format: [15:12] op, [11:10] rd, [9:8] rs, [7:0] imm.
- FSM states and transitions:
  - IDLE: on start go to FETCH.
  - FETCH: instr_req=1. On instr_valid, latch the word and go to DECODE. If FETCH_TIMEOUT cycles pass without instr_valid, set fetch_err and go to HALT.
  - DECODE (1 cycle): alu_a=R[rd], alu_b=R[rs], alu_load_number=imm. alu_opcode stays IDLE_OPCODE.
  - EXECUTE (1 cycle): alu_opcode=op. Operands are held stable.
  - WRITEBACK (1 cycle): R[rd] is loaded with alu_out as sampled at the end of EXECUTE. flags are updated per the opcode rules below. alu_opcode returns to IDLE_OPCODE and pc increments. Next state is FETCH.
  - HALT: busy=0, halted=1. start clears pc to 0 (registers preserved) and goes to FETCH.
- ALU re-trigger rule: the ALU evaluates only when its opcode changes. alu_opcode is therefore IDLE_OPCODE in every state except EXECUTE, so back-to-back identical opcodes still re-evaluate.
- Opcode handling:
  - 0000-0110 (ADD, SUB, AND, OR, XOR, SHL, SHR): write R[rd], flags <- alu_flag.
  - 1110 (LOAD): write R[rd] <- alu_out (= imm). flags unchanged.
  - 1111 (HALT): no ALU op; go from DECODE to HALT. pc is not incremented.
  - Any other opcode: NOP. Skip EXECUTE/WRITEBACK, increment pc, go to FETCH; no write, flags unchanged.
- Latency: ALU instruction = 4 cycles when instr_valid arrives 1 cycle after instr_req; NOP = 2 cycles.
- pc wraps from 2^PC_WIDTH-1 to 0.
- start is ignored while busy=1.
- instr_valid is ignored outside FETCH.

Optional Feature:
SEQ_BRANCH_EN
- Defined: branch opcodes are decoded with target = imm[PC_WIDTH-1:0]:
  - 1000 JZ: taken if flags==0010.
  - 1001 JC: taken if flags==1000.
  - 1010 JMP: always taken.
- Branches resolve in DECODE. Taken: pc <- target. Not taken: pc <- pc+1. Either way, go to FETCH with no ALU op and no flag change.
- Not defined: 1000, 1001 and 1010 are NOPs.

Test Plan:
- Program LOAD R0,0x05; LOAD R1,0x03; ADD R0,R1; HALT with instr_valid 1 cycle after instr_req -> R0=0x08, flags=0000, halted=1 on cycle 14 after start.
- R0=0xF0, R1=0x20, ADD R0,R1 -> R0=0x10, flags=1000. Then SUB of 0x07-0x07 -> 0x00, flags=0010. Then SUB of 0x03-0x05 -> 0xFE, flags=0100.
- Two consecutive XOR R2,R3 with R2=0x0F, R3=0xFF -> alu_opcode shows 1111 between them; R2=0xF0 then R2=0x0F.
- Hold instr_valid=0 for 16 cycles in FETCH -> fetch_err=1, halted=1, busy=0, pc unchanged.
- Assert rst during EXECUTE of ADD -> same cycle: alu_opcode=1111, busy=0; R[rd] keeps its pre-instruction value (0 after reset).
- SEQ_BRANCH_EN defined, flags=0010, JZ 0x20 at pc=0x04 -> next instr_addr=0x20. Same case with flags=0000 -> next instr_addr=0x05. Without the macro -> next instr_addr=0x05.
